// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: single-outstanding load/store bus controller.
//   Accepts one memory op from the pipeline, checks alignment, drives one
//   word-aligned bus access with byte enables and lane-replicated write data,
//   extends the load result, and pulses done_o (with err_o on fault/timeout).
// Ports:
//   clk, reset (async, active low)
//   pipeline : valid_i, we_i, swhb_i, lunsigned_i, addr_i, wdata_i ->
//              ready_o, stall_o, done_o, err_o, rdata_o
//   bus      : bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o <-
//              bus_ack_i, bus_rdata_i
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        we_i,
  input  logic [1:0]  swhb_i,
  input  logic        lunsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_we, r_uns, r_err;
  logic [1:0]    r_swhb;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [CW-1:0] r_cnt;

  logic          w_idle, w_bus, w_accept, w_fault, w_ack, w_tmo;
  logic [3:0]    w_be;
  logic [31:0]   w_bwdata, w_lane, w_ext;

  assign w_idle   = (r_state == S_IDLE);
  assign w_bus    = (r_state == S_BUS);
  assign w_accept = valid_i & w_idle;

  // Alignment check is on the live inputs so a fault never reaches the bus.
  assign w_fault  = (swhb_i == 2'b00) |
                    ((swhb_i == 2'b10) & addr_i[0]) |
                    ((swhb_i == 2'b01) & (addr_i[1:0] != 2'b00));

  assign w_ack    = w_bus & bus_ack_i;
  // Ack in the timeout cycle takes priority, hence ~bus_ack_i here.
  assign w_tmo    = w_bus & ~bus_ack_i & (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (valid_i) w_next = w_fault ? S_DONE : S_BUS;
      S_BUS:  if (bus_ack_i || w_tmo) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_swhb  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= we_i;
        r_uns   <= lunsigned_i;
        r_swhb  <= swhb_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_err   <= w_fault;
        r_cnt   <= '0;
      end else if (w_bus && !bus_ack_i) begin
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_tmo) r_err <= 1'b1;
      // Only a completed load updates rdata; stores and faults leave it.
      if (w_ack && !r_we) r_rdata <= w_ext;
    end
  end

  always_comb begin
    w_be     = 4'b0000;
    w_bwdata = r_wdata;
    case (r_swhb)
      2'b01: w_be = 4'b1111;
      2'b10: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_bwdata = {2{r_wdata[15:0]}};
      end
      2'b11: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_bwdata = {4{r_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bits [15:0]/[7:0] before extending.
  assign w_lane = bus_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = bus_rdata_i;
    case (r_swhb)
      2'b10: w_ext = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
      2'b11: w_ext = {{24{~r_uns & w_lane[7]}},  w_lane[7:0]};
      default: ;
    endcase
  end

  assign ready_o     = w_idle;
  // Gated by reset so every output except ready_o is 0 while in reset.
  assign stall_o     = reset & ((w_idle & valid_i) | w_bus);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = done_o & r_err;
  assign rdata_o     = r_rdata;
  assign bus_req_o   = w_bus;
  assign bus_we_o    = w_bus & r_we;
  assign bus_addr_o  = w_bus ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus_be_o    = w_bus ? w_be : 4'b0000;
  assign bus_wdata_o = w_bus ? w_bwdata : 32'h0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed vectors with hand-computed expectations for
// lsu_bus_ctrl (TIMEOUT=16).
module tb_lsu_bus_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, we_i, lunsigned_i;
  logic [1:0]  swhb_i;
  logic [31:0] addr_i, wdata_i;
  logic        ready_o, stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int errs = 0;
  int checks = 0;

  lsu_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .we_i(we_i), .swhb_i(swhb_i), .lunsigned_i(lunsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access. ack_at: BUS cycle (1-based) to ack in, 0 = never, -1 = fault expected.
  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic eerr, input logic [31:0] erd);
    int n;
    int exp_n;
    we_i = we; swhb_i = sz; lunsigned_i = uns; addr_i = a; wdata_i = wd; valid_i = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
    chk({tag, "_stall_acc"}, 32'(stall_o), 32'd1);
    step();
    // Scramble inputs: the registered copies must drive the access.
    valid_i = 1'b0; addr_i = 32'h5A5A5A5A; wdata_i = 32'hA5A5A5A5;
    swhb_i = 2'b00; we_i = ~we; lunsigned_i = ~uns;
    #1;
    n = 0;
    if (ack_at < 0) begin
      chk({tag, "_f_req"}, 32'(bus_req_o), 32'd0);
      chk({tag, "_f_done"}, 32'(done_o), 32'd1);
      chk({tag, "_f_err"}, 32'(err_o), 32'd1);
    end else begin
      exp_n = (ack_at > 0) ? ack_at : TIMEOUT;
      while (n < 40 && !done_o) begin
        n++;
        chk({tag, "_req"}, 32'(bus_req_o), 32'd1);
        chk({tag, "_be"}, 32'(bus_be_o), 32'(ebe));
        chk({tag, "_bwd"}, bus_wdata_o, ewd);
        chk({tag, "_badr"}, bus_addr_o, {a[31:2], 2'b00});
        chk({tag, "_bwe"}, 32'(bus_we_o), 32'(we));
        chk({tag, "_stall"}, 32'(stall_o), 32'd1);
        if (n == ack_at) begin
          bus_ack_i = 1'b1; bus_rdata_i = rd;
        end
        step();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0BADF00D;
      end
      chk({tag, "_ncyc"}, 32'(n), 32'(exp_n));
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_err"}, 32'(err_o), 32'(eerr));
      chk({tag, "_req_off"}, 32'(bus_req_o), 32'd0);
    end
    chk({tag, "_rdata"}, rdata_o, erd);
    chk({tag, "_stall_dn"}, 32'(stall_o), 32'd0);
    chk({tag, "_rdy_dn"}, 32'(ready_o), 32'd0);
    step();
    chk({tag, "_done_1cyc"}, 32'(done_o), 32'd0);
    chk({tag, "_rdy_back"}, 32'(ready_o), 32'd1);
    chk({tag, "_err_off"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    reset = 1'b0; valid_i = 1'b1; we_i = 1'b1; swhb_i = 2'b01; lunsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    #3;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_bus", {bus_addr_o[27:0], bus_be_o}, 32'h0);
    step(); step();
    valid_i = 1'b0; bus_ack_i = 1'b0; reset = 1'b1;
    step();

    access("wst",   1'b1, 2'b01, 1'b0, 32'h80000004, 32'hDEADBEEF, 32'h0,        1,  4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
    access("lbs",   1'b0, 2'b11, 1'b0, 32'h80000003, 32'h0,        32'h80FF1234, 1,  4'b1000, 32'h0,        1'b0, 32'hFFFFFF80);
    access("lbu",   1'b0, 2'b11, 1'b1, 32'h80000003, 32'h0,        32'h80FF1234, 2,  4'b1000, 32'h0,        1'b0, 32'h00000080);
    access("lhs",   1'b0, 2'b10, 1'b0, 32'h80000002, 32'h0,        32'h8001FFFF, 1,  4'b1100, 32'h0,        1'b0, 32'hFFFF8001);
    access("shw",   1'b1, 2'b10, 1'b0, 32'h80000000, 32'h00001234, 32'h0,        1,  4'b0011, 32'h12341234, 1'b0, 32'hFFFF8001);
    access("sbt",   1'b1, 2'b11, 1'b0, 32'h80000001, 32'h000000AB, 32'h0,        2,  4'b0010, 32'hABABABAB, 1'b0, 32'hFFFF8001);
    access("lw",    1'b0, 2'b01, 1'b0, 32'h80000008, 32'h0,        32'hCAFEF00D, 3,  4'b1111, 32'h0,        1'b0, 32'hCAFEF00D);
    access("lhu0",  1'b0, 2'b10, 1'b1, 32'h80000000, 32'h0,        32'h8001FFFF, 1,  4'b0011, 32'h0,        1'b0, 32'h0000FFFF);
    access("lbs1",  1'b0, 2'b11, 1'b0, 32'h80000001, 32'h0,        32'h80FF8234, 1,  4'b0010, 32'h0,        1'b0, 32'hFFFFFF82);
    access("fhalf", 1'b0, 2'b10, 1'b0, 32'h80000001, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF82);
    access("fsz",   1'b0, 2'b00, 1'b0, 32'h80000000, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF82);
    access("fword", 1'b1, 2'b01, 1'b0, 32'h80000002, 32'h11111111, 32'h0,        -1, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF82);
    access("tmo",   1'b0, 2'b01, 1'b0, 32'h80000010, 32'h0,        32'h0,        0,  4'b1111, 32'h0,        1'b1, 32'hFFFFFF82);
    access("ack16", 1'b0, 2'b01, 1'b0, 32'h80000014, 32'h0,        32'h12345678, 16, 4'b1111, 32'h0,        1'b0, 32'h12345678);

    // Ack while idle must have no effect.
    bus_ack_i = 1'b1; bus_rdata_i = 32'h77777777;
    step();
    chk("ign_done", 32'(done_o), 32'd0);
    chk("ign_rdy", 32'(ready_o), 32'd1);
    step();
    chk("ign_rdata", rdata_o, 32'h12345678);
    bus_ack_i = 1'b0;

    // Reset in the 3rd BUS cycle.
    we_i = 1'b0; swhb_i = 2'b01; lunsigned_i = 1'b0; addr_i = 32'h80000020; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("mrst_bus1", 32'(bus_req_o), 32'd1);
    step(); step();
    chk("mrst_bus3", 32'(bus_req_o), 32'd1);
    reset = 1'b0;
    #1;
    chk("mrst_req", 32'(bus_req_o), 32'd0);
    chk("mrst_rdy", 32'(ready_o), 32'd1);
    chk("mrst_done", 32'(done_o), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("mrst_nodone", 32'(done_o), 32'd0);
    chk("mrst_noreq", 32'(bus_req_o), 32'd0);
    step();
    chk("mrst_nodone2", 32'(done_o), 32'd0);

    access("post",  1'b0, 2'b10, 1'b0, 32'h80000002, 32'h0,        32'h8001FFFF, 1,  4'b1100, 32'h0,        1'b0, 32'hFFFF8001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

endmodule
